// File: rtl/iddmm_cond_sub_if.sv
// Stream interface for the IDDMM conditional subtractor: one operand-word input
// stream (A, B, carry) and one result-word output stream, both ready/valid.
interface iddmm_cond_sub_if #(
    parameter int WORD_W = 128
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic              in_carry;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              out_sel;

    modport slave (
        input  in_valid, in_a, in_b, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_a, in_b, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/iddmm_cond_sub.sv
// Word-serial final correction for IDDMM: buffers A and A-B while the borrow
// ripples LSW first, then streams out whichever of the two is non-negative.
module iddmm_cond_sub #(
    parameter int WORD_W = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    iddmm_cond_sub_if.slave    io
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] in_cnt, out_cnt;
    logic              borrow;
    logic              sel;
    logic [WORD_W-1:0] abuf [N];
    logic [WORD_W-1:0] dbuf [N];
    logic [WORD_W:0]   sub;
    logic              in_acc, out_acc, in_last, out_last_w;

    // The extra top bit of the wide subtraction is the borrow out of this word.
    assign sub        = {1'b0, io.in_a} - {1'b0, io.in_b} - {{WORD_W{1'b0}}, borrow};
    assign in_last    = (in_cnt == LAST_IDX);
    assign out_last_w = (out_cnt == LAST_IDX);
    assign in_acc     = io.in_valid & io.in_ready;
    assign out_acc    = io.out_valid & io.out_ready;
    assign io.out_sel = sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        state_nx     = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.out_last  = 1'b0;
        io.out_data  = '0;
        case (state)
            LOAD: begin
                io.in_ready = rst_n;
                if (in_acc && in_last) state_nx = DRAIN;
            end
            DRAIN: begin
                io.out_valid = 1'b1;
                io.out_last  = out_last_w;
                io.out_data  = sel ? dbuf[out_cnt] : abuf[out_cnt];
                if (out_acc && out_last_w) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            borrow  <= 1'b0;
            sel     <= 1'b0;
        end else begin
            if (in_acc) begin
                if (in_last) begin
                    in_cnt <= '0;
                    borrow <= 1'b0;
                    sel    <= io.in_carry | ~sub[WORD_W];
                end else begin
                    in_cnt <= in_cnt + ADDR_W'(1);
                    borrow <= sub[WORD_W];
                end
            end
            if (out_acc) out_cnt <= out_last_w ? '0 : out_cnt + ADDR_W'(1);
        end
    end

    // Buffers carry no reset so they can map onto plain storage.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            abuf[in_cnt] <= io.in_a;
            dbuf[in_cnt] <= sub[WORD_W-1:0];
        end
    end
endmodule
